// File: rtl/ip_pkg.sv
// Shared definitions for the IPv4/UDP transmit path and its receive-side filter.
// Holds the transmit FSM state type, fixed header field values, byte offsets
// of each header field within the Ethernet frame, and the latched field bundle.
package ip_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAY,
    PAD,
    IFG
  } tx_state_t;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [7:0]  IP_TOS         = 8'h00;
  localparam logic [15:0] IP_FLAGS       = 16'h4000;
  localparam logic [15:0] IP_HDR_LEN     = 16'd20;

  // Byte offsets within the frame (no preamble, b=0 is the first DA byte).
  localparam int unsigned DST_MAC_OFS  = 0;
  localparam int unsigned SRC_MAC_OFS  = 6;
  localparam int unsigned ETYPE_OFS    = 12;
  localparam int unsigned IP_VER_OFS   = 14;
  localparam int unsigned IP_TOS_OFS   = 15;
  localparam int unsigned IP_LEN_OFS   = 16;
  localparam int unsigned IP_ID_OFS    = 18;
  localparam int unsigned IP_FLAGS_OFS = 20;
  localparam int unsigned IP_TTL_OFS   = 22;
  localparam int unsigned IP_PROTO_OFS = 23;
  localparam int unsigned IP_CSUM_OFS  = 24;
  localparam int unsigned IP_SRC_OFS   = 26;
  localparam int unsigned IP_DST_OFS   = 30;
  localparam int unsigned PAY_OFS      = 34;
  localparam int unsigned HDR_BYTES    = PAY_OFS;

  // Per-frame inputs captured when a start request is accepted.
  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [7:0]  pay_len;
  } tx_fields_t;

  // IPv4 total length for a given UDP-level payload byte count.
  function automatic logic [15:0] ip_total_len(input logic [7:0] pay_len);
    return IP_HDR_LEN + {8'h00, pay_len};
  endfunction

endpackage

// File: rtl/ip_hdr_csum.sv
// IPv4 header checksum.
// Purely combinational one's-complement sum over the ten 16-bit header words
// (checksum word taken as zero), folded twice and inverted.
// Ports:
//   total_len - IPv4 total length field
//   ip_id     - identification field
//   src_ip    - source address
//   dst_ip    - destination address
//   csum      - header checksum, ready to be placed at bytes 24..25
module ip_hdr_csum
  import ip_pkg::*;
#(
  parameter logic [7:0] IP_TTL   = 8'h40,
  parameter logic [7:0] IP_PROTO = 8'h11
) (
  input  logic [15:0] total_len,
  input  logic [15:0] ip_id,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  output logic [15:0] csum
);

  // Ten 16-bit words never exceed 0x9FFF6, so 20 bits hold the raw sum.
  logic [19:0] sum;
  logic [16:0] fold1;
  logic [15:0] fold2;

  always_comb begin
    sum = {4'h0, IP_VER_IHL, IP_TOS}
        + {4'h0, total_len}
        + {4'h0, ip_id}
        + {4'h0, IP_FLAGS}
        + {4'h0, IP_TTL, IP_PROTO}
        + {4'h0, src_ip[31:16]}
        + {4'h0, src_ip[15:0]}
        + {4'h0, dst_ip[31:16]}
        + {4'h0, dst_ip[15:0]};
    // After the first fold the value is at most 0x1000E, so the second fold
    // cannot carry again.
    fold1 = {1'b0, sum[15:0]} + {13'h0000, sum[19:16]};
    fold2 = fold1[15:0] + {15'h0000, fold1[16]};
    csum  = ~fold2;
  end

endmodule

// File: rtl/ip_frame_tx.sv
// Byte-serial Ethernet/IPv4/UDP frame generator for the GMAC transmit byte
// interface. Emits DA, SA, EtherType, a 20-byte IPv4 header with checksum and
// an incrementing payload, zero-pads to MIN_FRAME and enforces an IFG.
// The MAC adds preamble and FCS.
// Ports:
//   rxcoreclk    - clock
//   reset        - synchronous active-high reset
//   start        - one-cycle send request, sampled only when idle
//   dst_mac/src_mac/src_ip/dst_ip - frame addressing, latched on start
//   pay_len      - payload byte count (0..255), latched on start
//   pay_seed     - first payload byte, latched on start
//   gmac_tx_data - frame byte (0 when not valid)
//   gmac_tx_dvld - byte valid, continuous for the whole frame
//   busy         - frame or IFG in progress
//   done         - one-cycle pulse on the cycle after the last byte
module ip_frame_tx
  import ip_pkg::*;
#(
  parameter int unsigned IFG_CYCLES = 12,
  parameter int unsigned MIN_FRAME  = 60,
  parameter logic [7:0]  IP_TTL     = 8'h40,
  parameter logic [7:0]  IP_PROTO   = 8'h11
) (
  input  logic        rxcoreclk,
  input  logic        reset,
  input  logic        start,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  input  logic [7:0]  pay_len,
  input  logic [7:0]  pay_seed,
  output logic [7:0]  gmac_tx_data,
  output logic        gmac_tx_dvld,
  output logic        busy,
  output logic        done
);

  localparam logic [8:0] HDR_LAST = 9'(HDR_BYTES - 1);
  localparam logic [8:0] MIN_LAST = 9'(MIN_FRAME - 1);
  // Output bytes are registered one cycle behind the state, so the state
  // returns to IDLE one cycle before the last low output cycle; a start
  // sampled there puts b=0 on the wire exactly IFG_CYCLES low cycles after
  // the previous frame's last byte.
  localparam logic [7:0] IFG_LAST = 8'((IFG_CYCLES >= 2) ? IFG_CYCLES - 2 : 0);

  tx_state_t  state, state_next;
  tx_fields_t fields_q;
  logic [8:0]  b_cnt;
  logic [7:0]  ifg_cnt;
  logic [7:0]  pay_byte;
  logic [15:0] ip_id;
  logic [15:0] total_len;
  logic [15:0] csum;
  logic        pay_last;

  logic [7:0]  tx_data_d;
  logic        tx_dvld_d;
  logic        done_d;

  // Header bytes in wire order; element index equals frame byte offset.
  logic [0:HDR_BYTES-1][7:0] hdr_bytes;

  assign total_len = ip_total_len(fields_q.pay_len);

  ip_hdr_csum #(
    .IP_TTL   (IP_TTL),
    .IP_PROTO (IP_PROTO)
  ) u_csum (
    .total_len (total_len),
    .ip_id     (ip_id),
    .src_ip    (fields_q.src_ip),
    .dst_ip    (fields_q.dst_ip),
    .csum      (csum)
  );

  assign hdr_bytes = {fields_q.dst_mac, fields_q.src_mac, ETHERTYPE_IPV4,
                      IP_VER_IHL, IP_TOS, total_len, ip_id, IP_FLAGS,
                      IP_TTL, IP_PROTO, csum, fields_q.src_ip, fields_q.dst_ip};

  assign pay_last = (b_cnt == HDR_LAST + {1'b0, fields_q.pay_len});
  assign busy     = (state != IDLE);

  // State register
  always_ff @(posedge rxcoreclk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = HDR;
      HDR: begin
        if (b_cnt == HDR_LAST) begin
          if (fields_q.pay_len != 8'd0) state_next = PAY;
          else if (HDR_LAST < MIN_LAST)  state_next = PAD;
          else                           state_next = IFG;
        end
      end
      PAY: begin
        if (pay_last) state_next = (b_cnt < MIN_LAST) ? PAD : IFG;
      end
      PAD: if (b_cnt >= MIN_LAST) state_next = IFG;
      IFG: if (ifg_cnt == IFG_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic (registered below)
  always_comb begin
    tx_data_d = '0;
    tx_dvld_d = 1'b0;
    done_d    = 1'b0;
    unique case (state)
      HDR: begin
        tx_dvld_d = 1'b1;
        tx_data_d = hdr_bytes[b_cnt[5:0]];
      end
      PAY: begin
        tx_dvld_d = 1'b1;
        tx_data_d = pay_byte;
      end
      PAD: tx_dvld_d = 1'b1;
      IFG: done_d = (ifg_cnt == '0);
      default: ;
    endcase
  end

  // Datapath: latched fields, counters, ip_id and output registers
  always_ff @(posedge rxcoreclk) begin
    if (reset) begin
      fields_q     <= '0;
      pay_byte     <= '0;
      b_cnt        <= '0;
      ifg_cnt      <= '0;
      ip_id        <= '0;
      gmac_tx_data <= '0;
      gmac_tx_dvld <= 1'b0;
      done         <= 1'b0;
    end else begin
      gmac_tx_data <= tx_data_d;
      gmac_tx_dvld <= tx_dvld_d;
      done         <= done_d;

      if (state == IDLE) begin
        b_cnt <= '0;
        if (start) begin
          fields_q <= {dst_mac, src_mac, src_ip, dst_ip, pay_len};
          pay_byte <= pay_seed;
        end
      end else if (state != IFG) begin
        b_cnt <= b_cnt + 9'd1;
      end

      if (state == PAY) pay_byte <= pay_byte + 8'd1;

      ifg_cnt <= (state == IFG && state_next == IFG) ? ifg_cnt + 8'd1 : '0;

      if (done_d) ip_id <= ip_id + 16'd1;
    end
  end

endmodule

// File: doc/ip_frame_tx.md
Name: ip_frame_tx

Overview:
Byte-serial Ethernet/IPv4/UDP frame generator for the transmit side of the GMAC byte interface; it is the counterpart of the receive-side IP filter.
- On a start pulse it emits one frame on gmac_tx_data/gmac_tx_dvld in this order: destination MAC, source MAC, EtherType 0x0800, 20-byte IPv4 header with computed checksum, then payload.
- The source IP lands at frame bytes 26..29, the same offset the receive filter checks.
- The MAC appends preamble and FCS; this block emits neither.

Parameters:
- IFG_CYCLES, 12, idle cycles with dvld low enforced after each frame.
- MIN_FRAME, 60, minimum emitted byte count; shorter frames are zero-padded up to it.
- IP_TTL, 8'h40, TTL field.
- IP_PROTO, 8'h11, protocol field.

Ports:
- rxcoreclk, input, 1, clock.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, single-cycle request to send one frame.
- dst_mac, input, 48, destination MAC.
- src_mac, input, 48, source MAC.
- src_ip, input, 32, IPv4 source address.
- dst_ip, input, 32, IPv4 destination address.
- pay_len, input, 8, payload byte count (0..255).
- pay_seed, input, 8, first payload byte; the payload increments mod 256 from it.
- gmac_tx_data, output, 8, frame byte.
- gmac_tx_dvld, output, 1, byte valid.
- busy, output, 1, high from the accepted start through the end of the IFG.
- done, output, 1, one-cycle pulse on the cycle after the last byte.

Behaviour:
- Reset: reset, synchronous, active-high; clock rxcoreclk.
  - Reset values: gmac_tx_data=0, gmac_tx_dvld=0, busy=0, done=0, state=IDLE, ip_id=0, all counters 0.
  - Reset asserted mid-frame forces dvld=0 on the next edge.
  - No resumption after reset; ip_id returns to 0.
- Start and latching:
  - start is sampled only in IDLE. When sampled high, all field inputs are latched and busy=1 on the next edge.
  - start is ignored whenever busy=1; no queueing.
  - Latency: start high at edge t gives the first byte (dst_mac[47:40]) with dvld=1 at edge t+1.
- Byte ordering: multi-byte fields are MSB first.
- Frame layout by byte index b:
  - b=0..5: dst_mac.
  - b=6..11: src_mac.
  - b=12..13: 0x08, 0x00.
  - b=14: 0x45.
  - b=15: 0x00.
  - b=16..17: total_len = 20 + pay_len, 16-bit, so max is 275.
  - b=18..19: ip_id.
  - b=20..21: 0x40, 0x00 (DF set).
  - b=22: IP_TTL.
  - b=23: IP_PROTO.
  - b=24..25: checksum.
  - b=26..29: src_ip.
  - b=30..33: dst_ip.
  - b=34..: payload bytes pay_seed, pay_seed+1, ...
- Checksum:
  - One's-complement sum of the ten header 16-bit words, with the checksum word taken as 0.
  - Two end-around-carry folds, then bitwise invert.
  - Computed from the latched registers and stable before b=24.
- States:
  - IDLE -> HDR on start.
  - HDR (b=0..33) -> PAY if pay_len!=0, else PAD.
  - PAY: pay_len bytes -> PAD if 34+pay_len<MIN_FRAME, else IFG.
  - PAD: 0x00 bytes until a total of MIN_FRAME bytes -> IFG.
  - IFG: dvld=0 for IFG_CYCLES cycles -> IDLE. busy drops on the IDLE entry edge.
- dvld is continuous from b=0 to the last byte; there are no gaps inside a frame.
- done pulses on the first IFG cycle. ip_id increments by 1 (mod 65536) on that same edge.
- gmac_tx_data is 0 whenever dvld=0.
- Frame length: pay_len=0 gives 60 bytes; pay_len=26 gives exactly 60 with no pad; pay_len=255 gives 289 bytes.
- Byte counter is 9 bits and must not wrap within a frame.
- Payload byte wraps 0xFF -> 0x00.

Decomposition:
- Shared package ip_pkg holds:
  - state encodings IDLE/HDR/PAY/PAD/IFG;
  - ETHERTYPE_IPV4=16'h0800;
  - header offsets, including IP_SRC_OFS=26;
  - IP_VER_IHL=8'h45 and IP_FLAGS=16'h4000.
  The receive filter is to reuse IP_SRC_OFS from the same package.
- One sub-module, ip_hdr_csum: combinational 16-bit one's-complement checksum from the latched fields. The byte sequencer and FSM stay in ip_frame_tx.

Test Plan:
- Checksum and header: src_ip=C0A80178, dst_ip=C0A80101, pay_len=26, ip_id=0.
  - b=16..17 = 00 2E; b=24..25 = B6 F5; b=26..29 = C0 A8 01 78.
  - 60 bytes emitted with no pad; done pulses once.
- Loopback: same frame fed into the receive filter -> match=1. Repeat with src_ip=C0A80179 -> match=0.
- Padding: pay_len=0, pay_seed=0x55.
  - 60 bytes total; b=34..59 all 0x00; total_len=0x0014.
- Long frame with wrap: pay_len=255, pay_seed=0xF0.
  - 289 bytes; payload F0..FF, 00..EE.
  - dvld continuous for all 289 cycles.
- Back-to-back: start held high continuously.
  - Second frame's b=0 appears exactly IFG_CYCLES+1 cycles after the first frame's last byte (IFG, then the IDLE sample cycle).
  - ip_id=0x0001 in the second frame; start pulses during busy are ignored.
- Reset at b=40 of a frame:
  - dvld=0 and busy=0 on the next edge.
  - A subsequent start sends a full frame with ip_id=0.
